// File: rtl/hall_conditioner.sv
// Hall sensor conditioner: synchroniser, glitch filter, code classification, direction and period.
// Build option HALL_FAULT_LATCH_EN makes the fault output sticky until reset.
module hall_conditioner #(
    parameter int FILTER_CYCLES = 16,
    parameter int PERIOD_WIDTH  = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [2:0]              hall_raw,
    output logic [2:0]              hall,
    output logic                    hall_valid,
    output logic                    edge_strobe,
    output logic                    direction,
    output logic [PERIOD_WIDTH-1:0] period,
    output logic                    stalled,
    output logic                    fault
);

    localparam int                      CNT_W   = $clog2(FILTER_CYCLES + 1);
    localparam logic [CNT_W-1:0]        CNT_MAX = CNT_W'(FILTER_CYCLES);
    localparam logic [PERIOD_WIDTH-1:0] PMAX    = '1;

    // Forward rotation order: 001 > 011 > 010 > 110 > 100 > 101 > 001
    function automatic logic [2:0] fwd_next(input logic [2:0] code);
        logic [2:0] nxt;
        case (code)
            3'b001:  nxt = 3'b011;
            3'b011:  nxt = 3'b010;
            3'b010:  nxt = 3'b110;
            3'b110:  nxt = 3'b100;
            3'b100:  nxt = 3'b101;
            3'b101:  nxt = 3'b001;
            default: nxt = 3'b000;
        endcase
        return nxt;
    endfunction

    function automatic logic code_legal(input logic [2:0] code);
        return (code != 3'b000) && (code != 3'b111);
    endfunction

    function automatic logic [CNT_W-1:0] filt_sat_inc(input logic [CNT_W-1:0] cnt);
        return (cnt >= CNT_MAX) ? CNT_MAX : cnt + 1'b1;
    endfunction

    function automatic logic [PERIOD_WIDTH-1:0] period_sat_inc(input logic [PERIOD_WIDTH-1:0] cnt);
        return (cnt == PMAX) ? PMAX : cnt + 1'b1;
    endfunction

    logic [2:0]              hall_sync_p0;
    logic [2:0]              hall_sync_p1;
    logic [2:0]              candidate;
    logic [CNT_W-1:0]        filt_count;
    logic [PERIOD_WIDTH-1:0] cycle_count;

    logic             same;
    logic [CNT_W-1:0] filt_count_next;
    logic             accept;
    logic             new_legal;
    logic             old_legal;
    logic             is_fwd;
    logic             is_rev;
    logic             fault_evt;

    always_comb begin
        same            = (hall_sync_p1 == candidate);
        filt_count_next = same ? filt_sat_inc(filt_count) : CNT_W'(1);
        accept          = same && (filt_count_next == CNT_MAX) && (candidate != hall);
        new_legal       = code_legal(candidate);
        old_legal       = code_legal(hall);
        is_fwd          = new_legal && old_legal && (fwd_next(hall) == candidate);
        is_rev          = new_legal && old_legal && (fwd_next(candidate) == hall);
        // Skips between two legal codes and any entry into 000/111 are faults
        fault_evt       = accept && (!new_legal || (old_legal && !is_fwd && !is_rev));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            hall_sync_p0 <= 3'b000;
            hall_sync_p1 <= 3'b000;
            candidate    <= 3'b000;
            filt_count   <= '0;
            hall         <= 3'b000;
            hall_valid   <= 1'b0;
            edge_strobe  <= 1'b0;
            direction    <= 1'b1;
            fault        <= 1'b0;
        end else begin
            // Stage p0/p1: two-flop synchroniser on the asynchronous sensor inputs
            hall_sync_p0 <= hall_raw;
            hall_sync_p1 <= hall_sync_p0;

            // Filter and classification stage
            if (!same) begin
                candidate <= hall_sync_p1;
            end
            filt_count  <= filt_count_next;
            edge_strobe <= is_fwd || is_rev ? accept : 1'b0;
            if (accept) begin
                hall       <= candidate;
                hall_valid <= new_legal;
                if (is_fwd) begin
                    direction <= 1'b1;
                end else if (is_rev) begin
                    direction <= 1'b0;
                end
            end
`ifdef HALL_FAULT_LATCH_EN
            fault <= fault | fault_evt;
`else
            fault <= fault_evt;
`endif
        end
    end

    // Period stage: runs one cycle behind the strobe, counter restarts at 1
    always_ff @(posedge clock) begin
        if (reset) begin
            cycle_count <= PMAX;
            period      <= PMAX;
            stalled     <= 1'b1;
        end else if (edge_strobe) begin
            cycle_count <= PERIOD_WIDTH'(1);
            period      <= cycle_count;
            stalled     <= 1'b0;
        end else begin
            cycle_count <= period_sat_inc(cycle_count);
            if (period_sat_inc(cycle_count) == PMAX) begin
                stalled <= 1'b1;
                period  <= PMAX;
            end
        end
    end

endmodule

// File: tb/tb_hall_conditioner.sv
// Directed, table-driven bench for hall_conditioner with default parameters.
module tb_hall_conditioner;

    localparam int HOLD = 200;

    logic        clock = 1'b0;
    logic        reset;
    logic [2:0]  hall_raw;
    logic [2:0]  hall;
    logic        hall_valid;
    logic        edge_strobe;
    logic        direction;
    logic [15:0] period;
    logic        stalled;
    logic        fault;

    int errors = 0;
    int checks = 0;
    logic sticky_exp = 1'b0;

    hall_conditioner #(.FILTER_CYCLES(16), .PERIOD_WIDTH(16)) dut (
        .clock(clock),
        .reset(reset),
        .hall_raw(hall_raw),
        .hall(hall),
        .hall_valid(hall_valid),
        .edge_strobe(edge_strobe),
        .direction(direction),
        .period(period),
        .stalled(stalled),
        .fault(fault)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [2:0]  raw;
        logic        exp_valid;
        int          exp_strobes;
        logic        exp_dir;
        logic [15:0] exp_period;
        logic        exp_stalled;
        int          exp_fault;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_hall"}, 32'(hall), 32'h0);
        check({tag, "_valid"}, 32'(hall_valid), 32'h0);
        check({tag, "_strobe"}, 32'(edge_strobe), 32'h0);
        check({tag, "_dir"}, 32'(direction), 32'h1);
        check({tag, "_period"}, 32'(period), 32'hFFFF);
        check({tag, "_stalled"}, 32'(stalled), 32'h1);
        check({tag, "_fault"}, 32'(fault), 32'h0);
    endtask

    task automatic run_vec(input int idx);
        vec_t v;
        int   strobes;
        int   fault_cycles;
        int   lat;
        v            = vecs[idx];
        strobes      = 0;
        fault_cycles = 0;
        lat          = -1;
        hall_raw     = v.raw;
        for (int c = 1; c <= HOLD; c++) begin
            @(negedge clock);
            if (edge_strobe) strobes++;
            if (fault) fault_cycles++;
            if (lat < 0 && hall == v.raw) lat = c;
        end
        check($sformatf("v%0d_hall", idx), 32'(hall), 32'(v.raw));
        check($sformatf("v%0d_latency", idx), 32'(lat), 32'd18);
        check($sformatf("v%0d_valid", idx), 32'(hall_valid), 32'(v.exp_valid));
        check($sformatf("v%0d_strobes", idx), 32'(strobes), 32'(v.exp_strobes));
        check($sformatf("v%0d_dir", idx), 32'(direction), 32'(v.exp_dir));
        check($sformatf("v%0d_period", idx), 32'(period), 32'(v.exp_period));
        check($sformatf("v%0d_stalled", idx), 32'(stalled), 32'(v.exp_stalled));
`ifdef HALL_FAULT_LATCH_EN
        if (v.exp_fault != 0) sticky_exp = 1'b1;
        check($sformatf("v%0d_fault_level", idx), 32'(fault), 32'(sticky_exp));
`else
        check($sformatf("v%0d_fault_pulses", idx), 32'(fault_cycles), 32'(v.exp_fault));
`endif
    endtask

    initial begin
        int strobes;
        int seen;
        int waited;

        //          raw     valid strb dir  period     stall fault
        vecs[0]  = '{3'b001, 1'b1, 0, 1'b1, 16'hFFFF, 1'b1, 0};
        vecs[1]  = '{3'b011, 1'b1, 1, 1'b1, 16'hFFFF, 1'b0, 0};
        vecs[2]  = '{3'b010, 1'b1, 1, 1'b1, 16'd200,  1'b0, 0};
        vecs[3]  = '{3'b110, 1'b1, 1, 1'b1, 16'd200,  1'b0, 0};
        vecs[4]  = '{3'b100, 1'b1, 1, 1'b1, 16'd200,  1'b0, 0};
        vecs[5]  = '{3'b101, 1'b1, 1, 1'b1, 16'd200,  1'b0, 0};
        vecs[6]  = '{3'b001, 1'b1, 1, 1'b1, 16'd200,  1'b0, 0};
        vecs[7]  = '{3'b101, 1'b1, 1, 1'b0, 16'd200,  1'b0, 0};
        vecs[8]  = '{3'b100, 1'b1, 1, 1'b0, 16'd200,  1'b0, 0};
        vecs[9]  = '{3'b110, 1'b1, 1, 1'b0, 16'd200,  1'b0, 0};
        vecs[10] = '{3'b010, 1'b1, 1, 1'b0, 16'd200,  1'b0, 0};
        vecs[11] = '{3'b011, 1'b1, 1, 1'b0, 16'd200,  1'b0, 0};
        vecs[12] = '{3'b001, 1'b1, 1, 1'b0, 16'd200,  1'b0, 0};
        vecs[13] = '{3'b010, 1'b1, 0, 1'b0, 16'd16,   1'b0, 1};
        vecs[14] = '{3'b111, 1'b0, 0, 1'b0, 16'd16,   1'b0, 1};
        vecs[15] = '{3'b010, 1'b1, 0, 1'b0, 16'd16,   1'b0, 0};
        vecs[16] = '{3'b110, 1'b1, 1, 1'b1, 16'hFFFF, 1'b0, 0};

        reset    = 1'b1;
        hall_raw = 3'b000;
        repeat (4) @(negedge clock);
        check_reset_values("reset");
        reset = 1'b0;

        for (int i = 0; i <= 12; i++) run_vec(i);

        // 15-cycle glitch must be rejected
        strobes  = 0;
        hall_raw = 3'b011;
        repeat (15) @(negedge clock) if (edge_strobe) strobes++;
        hall_raw = 3'b001;
        repeat (40) @(negedge clock) if (edge_strobe) strobes++;
        check("glitch15_hall", 32'(hall), 32'h1);
        check("glitch15_strobes", 32'(strobes), 32'd0);
        check("glitch15_dir", 32'(direction), 32'h0);

        // 16-cycle pulse is accepted, then the return is a reverse step 16 cycles later
        strobes  = 0;
        seen     = 0;
        hall_raw = 3'b011;
        repeat (16) @(negedge clock) begin
            if (edge_strobe) strobes++;
            if (hall == 3'b011) seen++;
        end
        hall_raw = 3'b001;
        repeat (40) @(negedge clock) begin
            if (edge_strobe) strobes++;
            if (hall == 3'b011) seen++;
        end
        check("pulse16_seen", 32'(seen), 32'd16);
        check("pulse16_strobes", 32'(strobes), 32'd2);
        check("pulse16_hall", 32'(hall), 32'h1);
        check("pulse16_dir", 32'(direction), 32'h0);
        check("pulse16_period", 32'(period), 32'd16);

        for (int i = 13; i <= 15; i++) run_vec(i);

        // Stall: no edges until the period counter saturates
        waited = 0;
        while (!stalled && waited < 70000) begin
            @(negedge clock);
            waited++;
        end
        check("stall_reached", 32'(stalled), 32'h1);
        check("stall_not_early", 32'(waited > 64000), 32'h1);
        check("stall_period", 32'(period), 32'hFFFF);

        run_vec(16);

        // Reset in the middle of filtering a new code
        strobes  = 0;
        hall_raw = 3'b011;
        repeat (8) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check_reset_values("midreset");
        reset = 1'b0;
        repeat (14) @(negedge clock) if (edge_strobe) strobes++;
        check("midreset_discard", 32'(hall), 32'h0);
        repeat (10) @(negedge clock) if (edge_strobe) strobes++;
        check("midreset_hall", 32'(hall), 32'h3);
        check("midreset_valid", 32'(hall_valid), 32'h1);
        check("midreset_strobes", 32'(strobes), 32'd0);
        check("midreset_fault", 32'(fault), 32'h0);
        check("midreset_period", 32'(period), 32'hFFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
